// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL bit positions and FSM state encoding.
package timer_pkg;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM_BIT   = 3;

    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

endpackage

// File: rtl/timer_dev_if.sv
// Peripheral-bus port bundle between the data-memory bridge and one timer window.
// WE is a one-cycle strobe with no ready: every write is accepted on the edge it
// is presented, and Dout is valid combinationally whenever Addr is stable.
interface timer_dev_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, output WE, output Din, input Dout, input IRQ);
    modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// Countdown timer with CTRL/PRESET/COUNT registers; raises IRQ on expiry,
// one-shot or periodic. FSM state is exported on state for checkers.
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus,
    output logic [1:0]  state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_flag;
    logic             reg_write;

    // Writes to COUNT or the unused slot are dropped and must not disturb the FSM.
    assign reg_write = bus.WE && (bus.Addr == CTRL_OFS || bus.Addr == PRESET_OFS);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            state    <= ST_IDLE;
        end else if (reg_write) begin
            if (bus.Addr == CTRL_OFS) ctrl   <= bus.Din[3:0];
            else                      preset <= bus.Din[CNT_W-1:0];
            irq_flag <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ctrl[EN_BIT]) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[EN_BIT]) begin
                        state <= ST_IDLE;
                    end else if (count <= CNT_ONE) begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    // Mode 1x behaves as one-shot; the flag stays latched until software writes.
                    if (ctrl[MODE_MSB:MODE_LSB] == MODE_PERIODIC) begin
                        irq_flag <= 1'b0;
                        state    <= ST_LOAD;
                    end else begin
                        ctrl[EN_BIT] <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.Dout = '0;
        case (bus.Addr)
            CTRL_OFS:   bus.Dout[3:0]       = ctrl;
            PRESET_OFS: bus.Dout[CNT_W-1:0] = preset;
            COUNT_OFS:  bus.Dout[CNT_W-1:0] = count;
            default:    bus.Dout            = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & ctrl[IM_BIT];

endmodule

// File: tb/tb_timer_dev.sv
// Randomised and directed bench for timer_dev: a timeline-based reference model
// predicts {state, IRQ, Dout}, a negedge monitor pops and compares.
module tb_timer_dev;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    timer_dev_if bus ();

    timer_dev #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: after entering LOAD (age 0) the run is a fixed timeline.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_age;

    logic [34:0] exp_q[$];
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] eff_len();
        return (m_preset == 32'd0) ? 32'd1 : m_preset;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_age < 0)                    return 2'd0;
        if (m_age == 0)                   return 2'd1;
        if (32'(m_age) <= eff_len())      return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic rst_i, input logic we_i,
                              input logic [1:0] a_i, input logic [31:0] d_i);
        if (rst_i) begin
            m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_age = -1;
        end else if (we_i && a_i <= 2'd1) begin
            if (a_i == 2'd0) m_ctrl = d_i[3:0];
            else             m_preset = d_i;
            m_flag = 1'b0;
            m_age  = -1;
        end else if (m_age < 0) begin
            if (m_ctrl[0]) m_age = 0;
        end else begin
            m_age = m_age + 1;
            if (32'(m_age) <= eff_len()) begin
                m_count = m_preset - 32'(m_age - 1);
            end else if (32'(m_age) == eff_len() + 32'd1) begin
                m_count = 32'd0;
                m_flag  = 1'b1;
            end else if (m_ctrl[2:1] == 2'b01) begin
                m_flag = 1'b0;
                m_age  = 0;
            end else begin
                m_ctrl[0] = 1'b0;
                m_age     = -1;
            end
        end
    endtask

    task automatic step(input logic rst_i, input logic we_i, input logic [1:0] a_i,
                        input logic [31:0] d_i, input bit chk);
        reset    = rst_i;
        bus.WE   = we_i;
        bus.Addr = a_i;
        bus.Din  = d_i;
        if (chk) exp_q.push_back({model_state(), m_flag & m_ctrl[3], model_read(a_i)});
        @(posedge clk);
        model_edge(rst_i, we_i, a_i, d_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, a, d, 1'b1);
    endtask

    task automatic rd_n(input logic [1:0] a, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 32'd0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [34:0] e;
            logic [34:0] g;
            e = exp_q.pop_front();
            g = {dbg_state, bus.IRQ, bus.Dout};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t addr=%0d: got state=%0d irq=%b dout=%h, expected state=%0d irq=%b dout=%h",
                         $time, bus.Addr, g[34:33], g[32], g[31:0], e[34:33], e[32], e[31:0]);
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_age = -1;

        // Reset held two cycles with writes pending, then every address reads 0.
        step(1'b1, 1'b1, 2'd0, 32'hF, 1'b0);
        step(1'b1, 1'b1, 2'd1, 32'h55, 1'b0);
        for (int a = 0; a < 4; a++) step(1'b0, 1'b0, 2'(a), 32'd0, 1'b1);

        // One-shot: COUNT 3,2,1,0 then latched IRQ, EN self-clears, CTRL=0 drops IRQ.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        rd_n(2'd2, 7);
        rd_n(2'd0, 2);
        wr(2'd0, 32'h0);
        rd_n(2'd0, 2);

        // Periodic: one-cycle pulses every 5 cycles.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        rd_n(2'd2, 18);

        // Masked: flag sets but IRQ stays 0; writing IM alone clears the flag.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        rd_n(2'd2, 6);
        wr(2'd0, 32'h8);
        rd_n(2'd0, 3);

        // PRESET write while COUNT=5 holds the count; COUNT writes are ignored.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        rd_n(2'd2, 7);
        wr(2'd1, 32'd10);
        rd_n(2'd2, 1);
        wr(2'd2, 32'h55);
        rd_n(2'd2, 2);

        // Clear EN at COUNT=7: value holds, no IRQ.
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h9);
        rd_n(2'd2, 4);
        wr(2'd0, 32'h8);
        rd_n(2'd2, 4);

        // PRESET=0 expires on the first count cycle.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        rd_n(2'd2, 5);

        // Randomised traffic, mostly reads so timers get a chance to expire.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0)
                step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'b1);
            else if (r == 0)
                wr(2'd0, {$urandom_range(0, 255), 24'd0} | 32'($urandom_range(0, 15)));
            else if (r == 1)
                wr(2'd1, ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 7)));
            else if (r == 2)
                wr(2'($urandom_range(2, 3)), $urandom);
            else
                step(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom, 1'b1);
        end

        bus.WE = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
